// File: rtl/rv32im_csr_pkg.sv
// Purpose : shared constants and types for the machine-mode CSR trap/MRET sequencer.
// Latency : n/a (package only).
// Backpr. : n/a.
// Contents: CSR addresses, funct3 codes, mstatus bit positions, mtvec modes,
//           FSM state encoding, CSR address legality helper.
package rv32im_csr_pkg;

   // Machine-mode CSR addresses served by the register file
   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MARCHID   = 12'hF12;
   localparam logic [11:0] CSR_MIMPID    = 12'hF13;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   // funct3 encodings of the Zicsr instructions
   localparam logic [2:0] F3_RW  = 3'b001;
   localparam logic [2:0] F3_RS  = 3'b010;
   localparam logic [2:0] F3_RC  = 3'b011;
   localparam logic [2:0] F3_RWI = 3'b101;
   localparam logic [2:0] F3_RSI = 3'b110;
   localparam logic [2:0] F3_RCI = 3'b111;

   // mstatus bit positions
   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   // mtvec.MODE values
   localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
   localparam logic [1:0] MTVEC_VECTORED = 2'b01;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_CSR_ACC  = 4'd1,
      ST_CSR_DONE = 4'd2,
      ST_T_EPC    = 4'd3,
      ST_T_CAUSE  = 4'd4,
      ST_T_TVAL   = 4'd5,
      ST_T_STAT   = 4'd6,
      ST_T_VEC    = 4'd7,
      ST_REDIR    = 4'd8,
      ST_M_STAT   = 4'd9,
      ST_M_EPC    = 4'd10
   } state_e;

   // True for addresses that exist in the register file
   function automatic logic csr_addr_legal(input logic [11:0] a);
      return a inside {CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC,
                       [CSR_MSCRATCH:CSR_MIP], [CSR_MVENDORID:CSR_MHARTID]};
   endfunction

endpackage

// File: rtl/rv32im_csr_alu.sv
// Purpose : computes the new CSR value and write enable for a Zicsr instruction.
// Latency : combinational.
// Backpr. : none.
// Ports   : i_op funct3, i_old current CSR value, i_operand rs1/uimm, i_wsup rs1/uimm index is zero;
//           o_wval new value, o_we write wanted, o_op_valid funct3 is a CSR op.
module rv32im_csr_alu
   import rv32im_csr_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      i_op,
   input  logic [XLEN-1:0] i_old,
   input  logic [XLEN-1:0] i_operand,
   input  logic            i_wsup,
   output logic [XLEN-1:0] o_wval,
   output logic            o_we,
   output logic            o_op_valid
);

   // Immediate forms behave identically: the operand is already zero-extended uimm.
   always_comb begin
      o_wval     = i_old;
      o_we       = 1'b0;
      o_op_valid = 1'b1;
      case (i_op)
         F3_RW, F3_RWI: begin
            o_wval = i_operand;
            o_we   = 1'b1;
         end
         F3_RS, F3_RSI: begin
            o_wval = i_old | i_operand;
            o_we   = ~i_wsup;
         end
         F3_RC, F3_RCI: begin
            o_wval = i_old & ~i_operand;
            o_we   = ~i_wsup;
         end
         default: o_op_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/rv32im_csr_trap_ctrl.sv
// Purpose : arbitrates the single CSR regfile port between CSR instructions and trap/MRET sequences.
// Latency : CSR done at accept+2; trap redirect at accept+6; MRET redirect at accept+3.
// Backpr. : ready only in IDLE (trap > mret > csr); nothing is queued while busy.
// Ports   : csr_* instruction request/response, trap_* / mret_* sequence requests,
//           redirect_* fetch redirect, busy_o, rf_* regfile port (combinational read).
module rv32im_csr_trap_ctrl
   import rv32im_csr_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter int              CSR_AW    = 12,
   parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              csr_valid_i,
   output logic              csr_ready_o,
   input  logic [2:0]        csr_op_i,
   input  logic [CSR_AW-1:0] csr_addr_i,
   input  logic [XLEN-1:0]   csr_operand_i,
   input  logic              csr_wsup_i,
   output logic              csr_done_o,
   output logic [XLEN-1:0]   csr_rdata_o,
   output logic              csr_illegal_o,
   input  logic              trap_valid_i,
   output logic              trap_ready_o,
   input  logic [XLEN-1:0]   trap_cause_i,
   input  logic [XLEN-1:0]   trap_epc_i,
   input  logic [XLEN-1:0]   trap_tval_i,
   input  logic              mret_valid_i,
   output logic              mret_ready_o,
   output logic              redirect_valid_o,
   output logic [XLEN-1:0]   redirect_pc_o,
   output logic              busy_o,
   output logic [CSR_AW-1:0] rf_addr_o,
   output logic              rf_re_o,
   output logic              rf_we_o,
   output logic [XLEN-1:0]   rf_wdata_o,
   input  logic [XLEN-1:0]   rf_rdata_i
);

   state_e            r_state;
   state_e            w_state_nxt;

   logic [2:0]        r_op;
   logic [CSR_AW-1:0] r_addr;
   logic [XLEN-1:0]   r_operand;
   logic              r_wsup;
   logic [XLEN-1:0]   r_cause;
   logic [XLEN-1:0]   r_epc;
   logic [XLEN-1:0]   r_tval;
   logic [XLEN-1:0]   r_csr_rdata;
   logic              r_illegal;
   logic [XLEN-1:0]   r_redir_pc;

   logic              w_idle;
   logic [XLEN-1:0]   w_alu_wval;
   logic              w_alu_we;
   logic              w_alu_op_valid;
   logic              w_illegal;
   logic [XLEN-1:0]   w_mstatus_trap;
   logic [XLEN-1:0]   w_mstatus_mret;
   logic [XLEN-1:0]   w_vec_base;
   logic [XLEN-1:0]   w_vec_target;
   logic              w_rf_we;
   logic [XLEN-1:0]   w_rf_wdata;

   // A request accepted on a reset edge would be silently lost, so readiness is
   // withheld while reset is asserted.
   assign w_idle       = (r_state == ST_IDLE) & ~rst_i;
   assign trap_ready_o = w_idle & trap_valid_i;
   assign mret_ready_o = w_idle & ~trap_valid_i & mret_valid_i;
   assign csr_ready_o  = w_idle & ~trap_valid_i & ~mret_valid_i & csr_valid_i;

   assign busy_o           = (r_state != ST_IDLE);
   assign csr_done_o       = (r_state == ST_CSR_DONE);
   assign csr_illegal_o    = (r_state == ST_CSR_DONE) & r_illegal;
   assign csr_rdata_o      = r_csr_rdata;
   assign redirect_valid_o = (r_state == ST_REDIR);
   assign redirect_pc_o    = r_redir_pc;

   rv32im_csr_alu #(.XLEN(XLEN)) u_alu (
      .i_op       (r_op),
      .i_old      (rf_rdata_i),
      .i_operand  (r_operand),
      .i_wsup     (r_wsup),
      .o_wval     (w_alu_wval),
      .o_we       (w_alu_we),
      .o_op_valid (w_alu_op_valid)
   );

   // Read-only space (addr[11:10]==11) is only illegal when a write would actually occur,
   // so CSRRS/CSRRC with x0 can still read the ID registers.
   assign w_illegal = ~csr_addr_legal(r_addr) | ~w_alu_op_valid
                    | ((r_addr[CSR_AW-1 -: 2] == 2'b11) & w_alu_we);

   // mstatus updates for trap entry and MRET, applied to the value read this cycle
   always_comb begin
      w_mstatus_trap                                = rf_rdata_i;
      w_mstatus_trap[MSTATUS_MPIE]                  = rf_rdata_i[MSTATUS_MIE];
      w_mstatus_trap[MSTATUS_MIE]                   = 1'b0;
      w_mstatus_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

      w_mstatus_mret                                = rf_rdata_i;
      w_mstatus_mret[MSTATUS_MIE]                   = rf_rdata_i[MSTATUS_MPIE];
      w_mstatus_mret[MSTATUS_MPIE]                  = 1'b1;
      w_mstatus_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
   end

   // Trap target from mtvec; only interrupts are vectored, exceptions go to base.
   always_comb begin
      w_vec_base = {rf_rdata_i[XLEN-1:2], 2'b00};
      if (rf_rdata_i == '0) begin
         w_vec_target = RESET_VEC;
      end else if ((rf_rdata_i[1:0] == MTVEC_VECTORED) && r_cause[XLEN-1]) begin
         w_vec_target = w_vec_base + XLEN'({r_cause[XLEN-2:0], 2'b00});
      end else begin
         w_vec_target = w_vec_base;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      rf_addr_o   = '0;
      rf_re_o     = 1'b0;
      w_rf_we     = 1'b0;
      w_rf_wdata  = '0;
      case (r_state)
         ST_IDLE: begin
            if (trap_ready_o) begin
               w_state_nxt = ST_T_EPC;
            end else if (mret_ready_o) begin
               w_state_nxt = ST_M_STAT;
            end else if (csr_ready_o) begin
               w_state_nxt = ST_CSR_ACC;
            end
         end
         ST_CSR_ACC: begin
            rf_addr_o   = r_addr;
            rf_re_o     = 1'b1;
            w_rf_we     = ~w_illegal & w_alu_we;
            w_rf_wdata  = w_alu_wval;
            w_state_nxt = ST_CSR_DONE;
         end
         ST_CSR_DONE: w_state_nxt = ST_IDLE;
         ST_T_EPC: begin
            rf_addr_o   = CSR_AW'(CSR_MEPC);
            w_rf_we     = 1'b1;
            w_rf_wdata  = r_epc & ~XLEN'(3);
            w_state_nxt = ST_T_CAUSE;
         end
         ST_T_CAUSE: begin
            rf_addr_o   = CSR_AW'(CSR_MCAUSE);
            w_rf_we     = 1'b1;
            w_rf_wdata  = r_cause;
            w_state_nxt = ST_T_TVAL;
         end
         ST_T_TVAL: begin
            rf_addr_o   = CSR_AW'(CSR_MTVAL);
            w_rf_we     = 1'b1;
            w_rf_wdata  = r_tval;
            w_state_nxt = ST_T_STAT;
         end
         ST_T_STAT: begin
            rf_addr_o   = CSR_AW'(CSR_MSTATUS);
            rf_re_o     = 1'b1;
            w_rf_we     = 1'b1;
            w_rf_wdata  = w_mstatus_trap;
            w_state_nxt = ST_T_VEC;
         end
         ST_T_VEC: begin
            rf_addr_o   = CSR_AW'(CSR_MTVEC);
            rf_re_o     = 1'b1;
            w_state_nxt = ST_REDIR;
         end
         ST_REDIR: w_state_nxt = ST_IDLE;
         ST_M_STAT: begin
            rf_addr_o   = CSR_AW'(CSR_MSTATUS);
            rf_re_o     = 1'b1;
            w_rf_we     = 1'b1;
            w_rf_wdata  = w_mstatus_mret;
            w_state_nxt = ST_M_EPC;
         end
         ST_M_EPC: begin
            rf_addr_o   = CSR_AW'(CSR_MEPC);
            rf_re_o     = 1'b1;
            w_state_nxt = ST_REDIR;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // The write that would coincide with a reset edge is dropped so an abandoned
   // sequence never commits its current step.
   assign rf_we_o    = w_rf_we & ~rst_i;
   assign rf_wdata_o = rf_we_o ? w_rf_wdata : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_op        <= '0;
         r_addr      <= '0;
         r_operand   <= '0;
         r_wsup      <= 1'b0;
         r_cause     <= '0;
         r_epc       <= '0;
         r_tval      <= '0;
         r_csr_rdata <= '0;
         r_illegal   <= 1'b0;
         r_redir_pc  <= '0;
      end else begin
         if (trap_ready_o) begin
            r_cause <= trap_cause_i;
            r_epc   <= trap_epc_i;
            r_tval  <= trap_tval_i;
         end
         if (csr_ready_o) begin
            r_op      <= csr_op_i;
            r_addr    <= csr_addr_i;
            r_operand <= csr_operand_i;
            r_wsup    <= csr_wsup_i;
         end
         case (r_state)
            ST_CSR_ACC: begin
               r_csr_rdata <= w_illegal ? '0 : rf_rdata_i;
               r_illegal   <= w_illegal;
            end
            ST_T_VEC: r_redir_pc <= w_vec_target;
            ST_M_EPC: r_redir_pc <= rf_rdata_i;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32im_csr_trap_ctrl.sv
// Purpose : directed self-checking bench for rv32im_csr_trap_ctrl with a behavioural CSR regfile.
// Latency : n/a.
// Backpr. : n/a.
module tb_rv32im_csr_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        csr_valid, csr_ready, csr_wsup, csr_done, csr_illegal;
   logic [2:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_operand, csr_rdata;
   logic        trap_valid, trap_ready;
   logic [31:0] trap_cause, trap_epc, trap_tval;
   logic        mret_valid, mret_ready;
   logic        redirect_valid, busy;
   logic [31:0] redirect_pc;
   logic [11:0] rf_addr;
   logic        rf_re, rf_we;
   logic [31:0] rf_wdata, rf_rdata;

   logic [31:0] rf_mem [0:4095];
   logic        poke_en = 1'b0;
   logic [11:0] poke_addr = '0;
   logic [31:0] poke_dat = '0;
   int          we_count = 0;

   int n_tests = 0;
   int n_fail  = 0;
   int lat;
   int we0;

   always #5 clk = ~clk;

   rv32im_csr_trap_ctrl #(.XLEN(32), .CSR_AW(12), .RESET_VEC(32'h0000_0080)) dut (
      .clk_i(clk), .rst_i(rst),
      .csr_valid_i(csr_valid), .csr_ready_o(csr_ready), .csr_op_i(csr_op),
      .csr_addr_i(csr_addr), .csr_operand_i(csr_operand), .csr_wsup_i(csr_wsup),
      .csr_done_o(csr_done), .csr_rdata_o(csr_rdata), .csr_illegal_o(csr_illegal),
      .trap_valid_i(trap_valid), .trap_ready_o(trap_ready), .trap_cause_i(trap_cause),
      .trap_epc_i(trap_epc), .trap_tval_i(trap_tval),
      .mret_valid_i(mret_valid), .mret_ready_o(mret_ready),
      .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc), .busy_o(busy),
      .rf_addr_o(rf_addr), .rf_re_o(rf_re), .rf_we_o(rf_we), .rf_wdata_o(rf_wdata),
      .rf_rdata_i(rf_rdata)
   );

   // Regfile model: combinational read, write on posedge; preload through the poke port
   assign rf_rdata = rf_mem[rf_addr];
   always @(posedge clk) begin
      if (rf_we) begin
         rf_mem[rf_addr] <= rf_wdata;
         we_count        <= we_count + 1;
      end else if (poke_en) begin
         rf_mem[poke_addr] <= poke_dat;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [11:0] a, input logic [31:0] d);
      poke_addr = a;
      poke_dat  = d;
      poke_en   = 1'b1;
      @(negedge clk);
      poke_en   = 1'b0;
   endtask

   // Issue a CSR instruction at a negedge, return accept->done latency in cycles
   task automatic do_csr(input logic [2:0] op, input logic [11:0] a, input logic [31:0] opnd,
                         input logic wsup, output int l);
      csr_op = op; csr_addr = a; csr_operand = opnd; csr_wsup = wsup; csr_valid = 1'b1;
      #1 chk("csr_ready", {31'd0, csr_ready}, 32'd1);
      @(negedge clk);
      csr_valid = 1'b0;
      l = 1;
      while (!csr_done && l < 20) begin
         @(negedge clk);
         l++;
      end
   endtask

   task automatic do_trap(input logic [31:0] c, input logic [31:0] e, input logic [31:0] t,
                          output int l);
      trap_cause = c; trap_epc = e; trap_tval = t; trap_valid = 1'b1;
      #1 chk("trap_ready", {31'd0, trap_ready}, 32'd1);
      @(negedge clk);
      trap_valid = 1'b0;
      l = 1;
      while (!redirect_valid && l < 20) begin
         @(negedge clk);
         l++;
      end
   endtask

   task automatic do_mret(output int l);
      mret_valid = 1'b1;
      #1 chk("mret_ready", {31'd0, mret_ready}, 32'd1);
      @(negedge clk);
      mret_valid = 1'b0;
      l = 1;
      while (!redirect_valid && l < 20) begin
         @(negedge clk);
         l++;
      end
   endtask

   initial begin
      rst = 1'b1;
      csr_valid = 1'b0; csr_op = '0; csr_addr = '0; csr_operand = '0; csr_wsup = 1'b0;
      trap_valid = 1'b0; trap_cause = '0; trap_epc = '0; trap_tval = '0;
      mret_valid = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_busy",     {31'd0, busy},           32'd0);
      chk("rst_done",     {31'd0, csr_done},       32'd0);
      chk("rst_redir_v",  {31'd0, redirect_valid}, 32'd0);
      chk("rst_redir_pc", redirect_pc,             32'd0);
      chk("rst_rdata",    csr_rdata,               32'd0);
      chk("rst_rf_we",    {31'd0, rf_we},          32'd0);
      chk("rst_rf_re",    {31'd0, rf_re},          32'd0);
      rst = 1'b0;
      @(negedge clk);

      poke(12'h340, 32'h0000_1234);
      poke(12'h300, 32'h0000_0008);
      poke(12'h305, 32'h0000_1001);
      poke(12'hF11, 32'h0000_0011);

      // CSRRW mscratch
      do_csr(3'b001, 12'h340, 32'hDEAD_BEEF, 1'b0, lat);
      chk("rw_latency", lat, 32'd2);
      chk("rw_rdata",   csr_rdata, 32'h0000_1234);
      chk("rw_illegal", {31'd0, csr_illegal}, 32'd0);
      @(negedge clk);
      chk("rw_mscratch", rf_mem[12'h340], 32'hDEAD_BEEF);

      // CSRRS mstatus with x0: read only
      we0 = we_count;
      do_csr(3'b010, 12'h300, 32'h0, 1'b1, lat);
      chk("rs_rdata", csr_rdata, 32'h0000_0008);
      @(negedge clk);
      chk("rs_no_write", we_count - we0, 32'd0);
      chk("rs_mstatus",  rf_mem[12'h300], 32'h0000_0008);

      // Write to read-only mvendorid
      do_csr(3'b001, 12'hF11, 32'h5, 1'b0, lat);
      chk("ro_illegal", {31'd0, csr_illegal}, 32'd1);
      chk("ro_rdata",   csr_rdata, 32'd0);
      @(negedge clk);
      chk("ro_nowrite", rf_mem[12'hF11], 32'h0000_0011);

      // CSRRSI x0 on read-only space is a legal read
      do_csr(3'b110, 12'hF11, 32'h0, 1'b1, lat);
      chk("roread_illegal", {31'd0, csr_illegal}, 32'd0);
      chk("roread_rdata",   csr_rdata, 32'h0000_0011);
      @(negedge clk);

      // Unimplemented address
      do_csr(3'b001, 12'h345, 32'h1, 1'b0, lat);
      chk("bad_addr_illegal", {31'd0, csr_illegal}, 32'd1);
      @(negedge clk);

      // Vectored interrupt trap
      do_trap(32'h8000_0007, 32'h0000_0102, 32'h0000_0055, lat);
      chk("trap_latency", lat, 32'd6);
      chk("trap_pc",      redirect_pc, 32'h0000_101C);
      chk("trap_mepc",    rf_mem[12'h341], 32'h0000_0100);
      chk("trap_mcause",  rf_mem[12'h342], 32'h8000_0007);
      chk("trap_mtval",   rf_mem[12'h343], 32'h0000_0055);
      chk("trap_mstatus", rf_mem[12'h300], 32'h0000_1880);
      @(negedge clk);

      // MRET
      do_mret(lat);
      chk("mret_latency", lat, 32'd3);
      chk("mret_pc",      redirect_pc, 32'h0000_0100);
      chk("mret_mstatus", rf_mem[12'h300], 32'h0000_1888);
      @(negedge clk);

      // All three requests together: trap, then mret, then csr
      trap_cause = 32'h0000_0002; trap_epc = 32'h0000_0200; trap_tval = 32'h0;
      csr_op = 3'b011; csr_addr = 12'h340; csr_operand = 32'h0000_000F; csr_wsup = 1'b0;
      trap_valid = 1'b1; mret_valid = 1'b1; csr_valid = 1'b1;
      #1;
      chk("prio_trap_rdy", {31'd0, trap_ready}, 32'd1);
      chk("prio_mret_rdy", {31'd0, mret_ready}, 32'd0);
      chk("prio_csr_rdy",  {31'd0, csr_ready},  32'd0);
      @(negedge clk);
      trap_valid = 1'b0;
      chk("busy_mret_rdy", {31'd0, mret_ready}, 32'd0);
      lat = 1;
      while (!redirect_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("prio_trap_lat", lat, 32'd6);
      chk("prio_trap_pc",  redirect_pc, 32'h0000_1000);
      chk("redir_mret_rdy", {31'd0, mret_ready}, 32'd0);
      @(negedge clk);
      chk("idle_mret_rdy", {31'd0, mret_ready}, 32'd1);
      chk("idle_csr_rdy",  {31'd0, csr_ready},  32'd0);
      @(negedge clk);
      mret_valid = 1'b0;
      lat = 1;
      while (!redirect_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("prio_mret_lat", lat, 32'd3);
      chk("prio_mret_pc",  redirect_pc, 32'h0000_0200);
      @(negedge clk);
      chk("idle_csr_rdy2", {31'd0, csr_ready}, 32'd1);
      @(negedge clk);
      csr_valid = 1'b0;
      lat = 1;
      while (!csr_done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("prio_csr_lat",   lat, 32'd2);
      chk("prio_csr_rdata", csr_rdata, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("rc_mscratch", rf_mem[12'h340], 32'hDEAD_BEE0);

      // mtvec of zero falls back to RESET_VEC
      poke(12'h305, 32'h0);
      do_trap(32'h8000_000B, 32'h0000_0300, 32'h0, lat);
      chk("zero_vec_pc", redirect_pc, 32'h0000_0080);
      @(negedge clk);

      // Reset during T_STAT
      poke(12'h300, 32'h0000_0008);
      poke(12'h305, 32'h0000_1001);
      trap_cause = 32'h0000_0005; trap_epc = 32'h0000_0407; trap_tval = 32'h0;
      trap_valid = 1'b1;
      @(negedge clk);
      trap_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("tstat_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("arst_busy",     {31'd0, busy},           32'd0);
      chk("arst_redir_v",  {31'd0, redirect_valid}, 32'd0);
      chk("arst_redir_pc", redirect_pc,             32'd0);
      chk("arst_rdata",    csr_rdata,               32'd0);
      chk("arst_rf_we",    {31'd0, rf_we},          32'd0);
      chk("arst_mepc",     rf_mem[12'h341],         32'h0000_0404);
      chk("arst_mcause",   rf_mem[12'h342],         32'h0000_0005);
      chk("arst_mstatus",  rf_mem[12'h300],         32'h0000_0008);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
